// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock with
// bounded retries, then releases the fast-domain reset and watches for lock loss.
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES     = 120,
    parameter int LOCK_TIMEOUT_CYCLES = 60000,
    parameter int LOCK_STABLE_CYCLES  = 1200,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       RESTART,
    output logic       PLL_RESETB,
    output logic       SYS_RESET_N,
    output logic       READY,
    output logic       FAULT,
    output logic       LOCK_LOST,
    output logic [1:0] RETRY_CNT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    // Terminal counts: each timed state leaves on the edge its counter reads N-1.
    localparam logic [15:0] HOLD_LAST    = 16'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]  RETRY_MAX    = 2'(MAX_RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [1:0]  retry_nxt;
    logic        lost_nxt;
    logic        lock_meta;
    logic        lock_s;

    // PLL_LOCK is asynchronous; only lock_s is used downstream.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = RETRY_CNT;
        lost_nxt  = LOCK_LOST;
        if (RESTART) begin
            state_nxt = S_HOLD;
            retry_nxt = 2'd0;
            lost_nxt  = 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (RETRY_CNT < RETRY_MAX) begin
                            retry_nxt = RETRY_CNT + 2'd1;
                            state_nxt = S_HOLD;
                        end else begin
                            state_nxt = S_FAULT;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                        retry_nxt = 2'd0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nxt = S_HOLD;
                        lost_nxt  = 1'b1;
                        retry_nxt = 2'd0;
                    end
                end
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_HOLD;
            endcase
        end

        // RUN and FAULT are untimed, so the counter just rests at zero there.
        cnt_nxt = cnt;
        if (RESTART || (state_nxt != state)) begin
            cnt_nxt = 16'd0;
        end else if (state == S_HOLD || state == S_WAIT_LOCK || state == S_STABLE) begin
            cnt_nxt = cnt + 16'd1;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as STATE.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_HOLD;
            cnt         <= 16'd0;
            RETRY_CNT   <= 2'd0;
            LOCK_LOST   <= 1'b0;
            PLL_RESETB  <= 1'b0;
            SYS_RESET_N <= 1'b0;
            READY       <= 1'b0;
            FAULT       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            RETRY_CNT   <= retry_nxt;
            LOCK_LOST   <= lost_nxt;
            PLL_RESETB  <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE) ||
                           (state_nxt == S_RUN);
            SYS_RESET_N <= (state_nxt == S_RUN);
            READY       <= (state_nxt == S_RUN);
            FAULT       <= (state_nxt == S_FAULT);
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed bring-up/fault/glitch/reset scenarios and
// random lock traffic, scored cycle by cycle against a phase/elapsed-time model.
module tb_pll_lock_sequencer;

    localparam int T_HOLD = 4;
    localparam int T_TO   = 20;
    localparam int T_ST   = 8;
    localparam int T_MAX  = 2;

    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_lock = 1'b0;
    logic restart = 1'b0;
    logic pll_resetb, sys_reset_n, ready, fault, lock_lost;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES    (T_HOLD),
        .LOCK_TIMEOUT_CYCLES(T_TO),
        .LOCK_STABLE_CYCLES (T_ST),
        .MAX_RETRIES        (T_MAX)
    ) dut (
        .REFERENCECLK(clk),
        .RESET       (rst_n),
        .PLL_LOCK    (pll_lock),
        .RESTART     (restart),
        .PLL_RESETB  (pll_resetb),
        .SYS_RESET_N (sys_reset_n),
        .READY       (ready),
        .FAULT       (fault),
        .LOCK_LOST   (lock_lost),
        .RETRY_CNT   (retry_cnt),
        .STATE       (state)
    );

    // Observed word: {STATE, RETRY_CNT, LOCK_LOST, FAULT, READY, SYS_RESET_N, PLL_RESETB}
    logic [9:0] dut_word;
    assign dut_word = {state, retry_cnt, lock_lost, fault, ready, sys_reset_n, pll_resetb};

    // ---------------- reference model ----------------
    int m_phase;
    int m_elapsed;
    int m_retry;
    bit m_lost;
    bit m_s1;
    bit m_s2;

    function automatic void model_reset();
        m_phase = P_HOLD;
        m_elapsed = 0;
        m_retry = 0;
        m_lost = 1'b0;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
    endfunction

    function automatic void enter(input int p);
        m_phase = p;
        m_elapsed = 0;
    endfunction

    // One rising edge: the FSM sees lock as it stood two edges ago.
    function automatic void model_step(input bit lk, input bit rs);
        bit seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (rs) begin
            enter(P_HOLD);
            m_retry = 0;
            m_lost = 1'b0;
            return;
        end
        m_elapsed = m_elapsed + 1;
        case (m_phase)
            P_HOLD: if (m_elapsed >= T_HOLD) enter(P_WAIT);
            P_WAIT: begin
                if (seen) enter(P_STABLE);
                else if (m_elapsed >= T_TO) begin
                    if (m_retry < T_MAX) begin
                        m_retry = m_retry + 1;
                        enter(P_HOLD);
                    end else begin
                        enter(P_FAULT);
                    end
                end
            end
            P_STABLE: begin
                if (!seen) enter(P_WAIT);
                else if (m_elapsed >= T_ST) begin
                    enter(P_RUN);
                    m_retry = 0;
                end
            end
            P_RUN: begin
                if (!seen) begin
                    m_lost = 1'b1;
                    m_retry = 0;
                    enter(P_HOLD);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [9:0] model_word();
        logic on, run, flt;
        on  = (m_phase == P_WAIT) || (m_phase == P_STABLE) || (m_phase == P_RUN);
        run = (m_phase == P_RUN);
        flt = (m_phase == P_FAULT);
        return {3'(m_phase), 2'(m_retry), m_lost, flt, run, run, on};
    endfunction

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b (state,retry,lost,fault,ready,sysn,resetb)",
                     name, cyc, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("sb", dut_word, e);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic lk, input logic rs);
        pll_lock = lk;
        restart  = rs;
        @(posedge clk);
        cyc++;
        model_step(lk, rs);
        #1;
        exp_q.push_back(model_word());
        restart = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        bit   hit;
        logic cur;
        int   run_left;

        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model_word());
        rst_n = 1'b1;

        // Normal bring-up, then lock loss in RUN and full re-sequence.
        repeat (30) drive_cycle(1'b1, 1'b0);
        repeat (2) drive_cycle(1'b0, 1'b0);
        repeat (30) drive_cycle(1'b1, 1'b0);

        // Never locks: three attempts then FAULT, held.
        repeat (90) drive_cycle(1'b0, 1'b0);

        // Restart out of FAULT.
        drive_cycle(1'b0, 1'b1);

        // Restart landing on the very edge of a lock timeout.
        hit = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            if (m_phase == P_WAIT && m_elapsed == T_TO - 1 && !m_s2) begin
                drive_cycle(1'b0, 1'b1);
                hit = 1'b1;
            end else begin
                drive_cycle(1'b0, 1'b0);
            end
        end

        // One-cycle lock glitch while STABLE has counted 5.
        for (int i = 0; i < 100; i++) begin
            if (m_phase == P_STABLE && m_elapsed == 5) break;
            drive_cycle(1'b1, 1'b0);
        end
        drive_cycle(1'b0, 1'b0);
        repeat (25) drive_cycle(1'b1, 1'b0);

        // Asynchronous reset mid-cycle while in RUN.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_word, 10'b0);
        @(posedge clk);
        #1;
        check("reset_held", dut_word, 10'b0);
        model_reset();
        exp_q.push_back(model_word());
        rst_n = 1'b1;

        // Random lock traffic with occasional restarts.
        run_left = 0;
        cur = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (run_left == 0) begin
                cur = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 40);
            end
            run_left--;
            drive_cycle(cur, ($urandom_range(0, 63) == 0));
        end

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter RST_HOLD_CYCLES, default 120, meaning cycles PLL_RESETB is held low per attempt (10 us at 12 MHz).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 60000, meaning max cycles waited for lock per attempt.
REQ-003 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1200, meaning consecutive locked cycles required before release.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, meaning re-attempts allowed after the first before FAULT.
REQ-005 The block SHALL have port REFERENCECLK, input, 1 bit, the single 12 MHz clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port PLL_LOCK, input, 1 bit, raw PLL LOCK, asynchronous to REFERENCECLK.
REQ-008 The block SHALL have port RESTART, input, 1 bit, synchronous single-cycle restart request.
REQ-009 The block SHALL have port PLL_RESETB, output, 1 bit, drives PLL RESETB (active low).
REQ-010 The block SHALL have port SYS_RESET_N, output, 1 bit, active-low reset for the 128 MHz datapath.
REQ-011 The block SHALL have outputs READY (1), FAULT (1) and LOCK_LOST (1): clock valid, retries exhausted, and sticky lock-loss seen.
REQ-012 The block SHALL have outputs RETRY_CNT (2) and STATE (3): failed attempts so far and current state encoding.

Function
REQ-013 PLL_LOCK SHALL pass through a 2-flop synchronizer (reset to 0) giving lock_s; no other logic samples PLL_LOCK.
REQ-014 States SHALL be HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4; other codes go to HOLD next cycle.
REQ-015 One 16-bit cycle counter SHALL serve all states, cleared on every state change; parameters are 2..65535.
REQ-016 HOLD SHALL last exactly RST_HOLD_CYCLES cycles, then WAIT_LOCK.
REQ-017 In WAIT_LOCK, lock_s=1 SHALL go to STABLE next edge; after LOCK_TIMEOUT_CYCLES cycles without lock_s, RETRY_CNT<MAX_RETRIES SHALL increment RETRY_CNT and go to HOLD, otherwise go to FAULT.
REQ-018 STABLE SHALL go to RUN after LOCK_STABLE_CYCLES consecutive cycles of lock_s=1; any lock_s=0 cycle SHALL go to WAIT_LOCK with the timeout restarted.
REQ-019 RUN SHALL hold while lock_s=1; lock_s=0 SHALL set LOCK_LOST, clear RETRY_CNT and go to HOLD.
REQ-020 Entering RUN SHALL clear RETRY_CNT.
REQ-021 FAULT SHALL be terminal until RESTART or RESET.
REQ-022 RESTART SHALL override all transitions in every state: go to HOLD, clear counter, RETRY_CNT and LOCK_LOST.
REQ-023 Outputs SHALL be registered, Moore, and updated on the edge the state changes. PLL_RESETB=1 only in WAIT_LOCK, STABLE and RUN. SYS_RESET_N=1 and READY=1 only in RUN. FAULT=1 only in FAULT.
REQ-024 RETRY_CNT SHALL saturate at MAX_RETRIES and never wrap.
REQ-025 Lock loss in RUN SHALL deassert READY/SYS_RESET_N within 3 edges of PLL_LOCK falling.

Reset
REQ-026 While RESET=0 the block SHALL asynchronously force state HOLD, counter 0, synchronizer 0, and outputs PLL_RESETB=0, SYS_RESET_N=0, READY=0, FAULT=0, LOCK_LOST=0, RETRY_CNT=0, STATE=0.
REQ-027 After RESET rises, counting SHALL begin on the first rising edge; reset mid-operation behaves identically.

Verification (RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2; edge 1 = first edge after RESET rises)
REQ-028 Normal bring-up: PLL_LOCK=1 constant -> PLL_RESETB=1 after edge 4, STATE=2 after edge 5, READY=SYS_RESET_N=1 after edge 13.
REQ-029 Never locks: PLL_LOCK=0 -> three 4-low/20-high PLL_RESETB attempts, then FAULT=1, RETRY_CNT=2, PLL_RESETB=0, held indefinitely.
REQ-030 Glitch in STABLE: PLL_LOCK low 1 cycle at STABLE count 5 -> STATE=1, then READY only after 8 further consecutive locked cycles.
REQ-031 Lock loss in RUN: drop PLL_LOCK -> READY=SYS_RESET_N=0 within 3 edges, LOCK_LOST=1, STATE=0, full re-sequence to RUN with LOCK_LOST still 1.
REQ-032 Recovery: RESTART pulse in FAULT -> STATE=0, FAULT=0, RETRY_CNT=0, LOCK_LOST=0 next edge; RESTART coinciding with a timeout wins.
REQ-033 Async reset in RUN: RESET low mid-cycle -> all outputs at reset values before the next edge.
